// File: rtl/avalon_pio_serial_out_if.sv
// ============================================================================
// Module      : avalon_pio_serial_out_if
// Description : Avalon-MM slave control-bus bundle for avalon_pio_serial_out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface avalon_pio_serial_out_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

`default_nettype wire

// File: rtl/avalon_pio_serial_out.sv
// ============================================================================
// Module      : avalon_pio_serial_out
// Description : Avalon-MM parallel output PIO with set/clear registers and a
//               programmable-rate serial shift engine (ser_clk/ser_data).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avalon_pio_serial_out #(
    parameter int          DATA_WIDTH  = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          DIV_WIDTH   = 16
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    avalon_pio_serial_out_if.slave      bus,
    output logic [DATA_WIDTH-1:0]       out_port,
    output logic                        ser_clk,
    output logic                        ser_data,
    output logic                        busy,
    output logic                        irq
);

    localparam logic [2:0] c_ADDR_DATA   = 3'd0;
    localparam logic [2:0] c_ADDR_SET    = 3'd1;
    localparam logic [2:0] c_ADDR_CLEAR  = 3'd2;
    localparam logic [2:0] c_ADDR_CTRL   = 3'd3;
    localparam logic [2:0] c_ADDR_SHIFT  = 3'd4;
    localparam logic [2:0] c_ADDR_STATUS = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2
    } state_t;

    state_t                 r_state;
    logic [DATA_WIDTH-1:0]  r_out_port;
    logic [DIV_WIDTH-1:0]   r_div;
    logic [4:0]             r_len_m1;
    logic                   r_msb_first;
    logic                   r_irq_en;
    logic [31:0]            r_shift_word;
    logic [DIV_WIDTH-1:0]   r_div_lat;
    logic                   r_msb_lat;
    logic [31:0]            r_sreg;
    logic [4:0]             r_bitcnt;
    logic [DIV_WIDTH-1:0]   r_phase;
    logic                   r_ser_clk;
    logic                   r_ser_data;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_ovf;

    logic        w_wr;
    logic        w_phase_end;
    logic        w_done_set;
    logic        w_ovf_set;
    logic [31:0] w_ctrl;
    logic [31:0] w_load_sreg;
    logic        w_first_bit;

    assign w_wr        = bus.chipselect & ~bus.write_n;
    assign w_phase_end = (r_phase == r_div_lat);
    assign w_done_set  = (r_state == S_HIGH) && w_phase_end && (r_bitcnt == 5'd0);
    assign w_ovf_set   = w_wr && (bus.address == c_ADDR_SHIFT) && (r_state != S_IDLE);

    // MSB-first words are left-aligned so the active bit always sits in sreg[31].
    assign w_load_sreg = r_msb_first ? (bus.writedata << (5'd31 - r_len_m1)) : bus.writedata;
    assign w_first_bit = r_msb_first ? bus.writedata[r_len_m1] : bus.writedata[0];

    always_comb begin
        w_ctrl                  = '0;
        w_ctrl[DIV_WIDTH-1:0]   = r_div;
        w_ctrl[20:16]           = r_len_m1;
        w_ctrl[24]              = r_msb_first;
        w_ctrl[25]              = r_irq_en;
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            c_ADDR_DATA:   bus.readdata = 32'(r_out_port);
            c_ADDR_CTRL:   bus.readdata = w_ctrl;
            c_ADDR_SHIFT:  bus.readdata = r_shift_word;
            c_ADDR_STATUS: bus.readdata = {29'd0, r_ovf, r_done, r_busy};
            default:       bus.readdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_out_port   <= RESET_VALUE[DATA_WIDTH-1:0];
            r_div        <= '0;
            r_len_m1     <= '0;
            r_msb_first  <= 1'b0;
            r_irq_en     <= 1'b0;
            r_shift_word <= '0;
            r_div_lat    <= '0;
            r_msb_lat    <= 1'b0;
            r_sreg       <= '0;
            r_bitcnt     <= '0;
            r_phase      <= '0;
            r_ser_clk    <= 1'b0;
            r_ser_data   <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            if (w_wr) begin
                case (bus.address)
                    c_ADDR_DATA:  r_out_port <= bus.writedata[DATA_WIDTH-1:0];
                    c_ADDR_SET:   r_out_port <= r_out_port | bus.writedata[DATA_WIDTH-1:0];
                    c_ADDR_CLEAR: r_out_port <= r_out_port & ~bus.writedata[DATA_WIDTH-1:0];
                    c_ADDR_CTRL: begin
                        r_div       <= bus.writedata[DIV_WIDTH-1:0];
                        r_len_m1    <= bus.writedata[20:16];
                        r_msb_first <= bus.writedata[24];
                        r_irq_en    <= bus.writedata[25];
                    end
                    c_ADDR_SHIFT: r_shift_word <= bus.writedata;
                    default: ;
                endcase
            end

            // Hardware set takes precedence over a coincident write-1-to-clear.
            r_done <= w_done_set | (r_done & ~(w_wr && (bus.address == c_ADDR_STATUS) && bus.writedata[1]));
            r_ovf  <= w_ovf_set  | (r_ovf  & ~(w_wr && (bus.address == c_ADDR_STATUS) && bus.writedata[2]));

            case (r_state)
                S_IDLE: begin
                    if (w_wr && (bus.address == c_ADDR_SHIFT)) begin
                        r_div_lat  <= r_div;
                        r_msb_lat  <= r_msb_first;
                        r_sreg     <= w_load_sreg;
                        r_bitcnt   <= r_len_m1;
                        r_phase    <= '0;
                        r_ser_data <= w_first_bit;
                        r_ser_clk  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (w_phase_end) begin
                        r_phase   <= '0;
                        r_ser_clk <= 1'b1;
                        r_state   <= S_HIGH;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (w_phase_end) begin
                        r_phase   <= '0;
                        r_ser_clk <= 1'b0;
                        if (r_bitcnt == 5'd0) begin
                            r_ser_data <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_bitcnt <= r_bitcnt - 5'd1;
                            if (r_msb_lat) begin
                                r_sreg     <= r_sreg << 1;
                                r_ser_data <= r_sreg[30];
                            end else begin
                                r_sreg     <= r_sreg >> 1;
                                r_ser_data <= r_sreg[1];
                            end
                            r_state <= S_LOW;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_port = r_out_port;
    assign ser_clk  = r_ser_clk;
    assign ser_data = r_ser_data;
    assign busy     = r_busy;
    assign irq      = r_done & r_irq_en;

endmodule

`default_nettype wire

// File: tb/tb_avalon_pio_serial_out.sv
// ============================================================================
// Module      : tb_avalon_pio_serial_out
// Description : Self-checking bench: register vector table, directed serial
//               corner cases and randomized transfers against a waveform model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_avalon_pio_serial_out;

    localparam logic [31:0] c_RESET_VALUE = 32'h5A;

    logic       clk;
    logic       reset;
    logic [7:0] out_port;
    logic       ser_clk;
    logic       ser_data;
    logic       busy;
    logic       irq;

    int checks   = 0;
    int failures = 0;

    avalon_pio_serial_out_if bus ();

    avalon_pio_serial_out #(
        .DATA_WIDTH  (8),
        .RESET_VALUE (c_RESET_VALUE),
        .DIV_WIDTH   (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .out_port (out_port),
        .ser_clk  (ser_clk),
        .ser_data (ser_data),
        .busy     (busy),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  wa;
        logic [31:0] wd;
        logic [2:0]  ra;
        logic [7:0]  exp_out;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the write applied.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    // Model: bit k of the stream is held for 2*(div+1) cycles, low half then high half.
    // inject 1: status W1C on the completion edge; inject 2: SHIFT write mid-transfer.
    task automatic xfer(input logic [31:0] ctrl, input logic [31:0] word, input int inject, input string tag);
        int          div;
        int          len;
        int          n;
        int          idx;
        int          ph;
        logic        msb;
        logic        expd;
        logic [31:0] r;
        div = int'(ctrl[15:0]);
        len = int'(ctrl[20:16]);
        msb = ctrl[24];
        n   = (len + 1) * 2 * (div + 1);
        wr(3'd3, ctrl);
        wr(3'd4, word);
        for (int t = 0; t < n; t++) begin
            idx  = t / (2 * (div + 1));
            ph   = t % (2 * (div + 1));
            expd = msb ? word[len - idx] : word[idx];
            check({tag, " wave"}, {29'd0, busy, ser_clk, ser_data},
                  {29'd0, 1'b1, (ph > div), expd});
            if (inject == 2 && t == 6) begin
                rd(3'd5, r);
                check({tag, " ovf status"}, r, 32'h5);
            end
            if (inject == 1 && t == n - 1) begin
                bus.address = 3'd5; bus.writedata = 32'h2;
                bus.chipselect = 1'b1; bus.write_n = 1'b0;
            end else if (inject == 2 && t == 5) begin
                bus.address = 3'd4; bus.writedata = ~word;
                bus.chipselect = 1'b1; bus.write_n = 1'b0;
            end
            @(negedge clk);
            bus.chipselect = 1'b0;
            bus.write_n    = 1'b1;
        end
        check({tag, " idle after"}, {29'd0, busy, ser_clk, ser_data}, 32'h1);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] ctrl;
        logic [31:0] word;

        vecs[0] = '{3'd0, 32'h0000_00A5, 3'd0, 8'hA5, 32'h0000_00A5};
        vecs[1] = '{3'd1, 32'h0000_000A, 3'd1, 8'hAF, 32'h0000_0000};
        vecs[2] = '{3'd2, 32'h0000_0081, 3'd0, 8'h2E, 32'h0000_002E};
        vecs[3] = '{3'd0, 32'hFFFF_FF3C, 3'd0, 8'h3C, 32'h0000_003C};
        vecs[4] = '{3'd6, 32'h0000_0055, 3'd0, 8'h3C, 32'h0000_003C};
        vecs[5] = '{3'd3, 32'hFFFF_FFFF, 3'd3, 8'h3C, 32'h031F_FFFF};
        vecs[6] = '{3'd2, 32'h0000_000C, 3'd2, 8'h30, 32'h0000_0000};
        vecs[7] = '{3'd3, 32'h0000_0000, 3'd5, 8'h30, 32'h0000_0000};

        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        reset          = 1'b1;
        repeat (2) @(negedge clk);
        check("reset out_port", {24'd0, out_port}, c_RESET_VALUE);
        check("reset serial", {28'd0, busy, ser_clk, ser_data, irq}, 32'h2);
        rd(3'd5, r);
        check("reset status", r, 32'h0);
        rd(3'd3, r);
        check("reset ctrl", r, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            wr(vecs[i].wa, vecs[i].wd);
            check($sformatf("vec%0d out_port", i), {24'd0, out_port}, {24'd0, vecs[i].exp_out});
            rd(vecs[i].ra, r);
            check($sformatf("vec%0d readdata", i), r, vecs[i].exp_rd);
        end

        xfer(32'h0103_0001, 32'hB, 0, "msb first");
        rd(3'd5, r);
        check("msb status done", r, 32'h2);
        rd(3'd4, r);
        check("shift readback", r, 32'hB);
        check("out_port untouched", {24'd0, out_port}, 32'h30);
        wr(3'd5, 32'h2);
        rd(3'd5, r);
        check("done cleared", r, 32'h0);

        xfer(32'h0003_0001, 32'hB, 0, "lsb first");
        wr(3'd5, 32'h2);

        xfer(32'h0203_0001, 32'h5, 0, "irq");
        check("irq high", {31'd0, irq}, 32'h1);
        wr(3'd5, 32'h2);
        check("irq cleared", {31'd0, irq}, 32'h0);

        xfer(32'h0203_0001, 32'hA, 1, "w1c race");
        rd(3'd5, r);
        check("w1c race done kept", r, 32'h2);
        check("w1c race irq", {31'd0, irq}, 32'h1);
        wr(3'd3, 32'h0003_0001);
        check("irq_en off", {31'd0, irq}, 32'h0);
        wr(3'd5, 32'h2);

        xfer(32'h0103_0001, 32'h9, 2, "ovf");
        rd(3'd5, r);
        check("ovf status after", r, 32'h6);
        wr(3'd5, 32'h6);
        rd(3'd5, r);
        check("ovf cleared", r, 32'h0);

        xfer(32'h001F_0000, $urandom, 0, "len32 div0");
        wr(3'd5, 32'h2);

        for (int k = 0; k < 6; k++) begin
            ctrl = {7'd0, 1'($urandom_range(0, 1)), 3'd0, 5'($urandom_range(0, 31)),
                    16'($urandom_range(0, 3))};
            word = $urandom;
            xfer(ctrl, word, 0, $sformatf("rand%0d", k));
            wr(3'd5, 32'h2);
        end

        wr(3'd3, 32'h0107_0001);
        wr(3'd4, 32'h0000_00F0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort serial", {29'd0, busy, ser_clk, ser_data}, 32'h1);
        check("abort out_port", {24'd0, out_port}, c_RESET_VALUE);
        rd(3'd5, r);
        check("abort status", r, 32'h0);
        rd(3'd3, r);
        check("abort ctrl", r, 32'h0);
        xfer(32'h0107_0000, 32'hC3, 0, "after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/avalon_pio_serial_out.md
Name: avalon_pio_serial_out

Overview:
Parametrised successor to the team's single-bit Avalon-MM output PIO. It provides a DATA_WIDTH-bit parallel output port with atomic bit-set and bit-clear registers. It adds a serial shift engine that clocks a written word out on ser_clk/ser_data at a programmable rate, for bit-banged Ethernet PHY management and similar side-band links. It sits on the Avalon-MM control bus as a simple slave with zero-wait-state writes and combinational read data.

Parameters:
DATA_WIDTH, 8, width of out_port (1..32)
RESET_VALUE, 0, out_port value after reset
DIV_WIDTH, 16, width of the serial half-period divider field (1..16)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
address  input  3  register word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0
writedata  input  32  write data
readdata  output  32  combinational read data for the current address
out_port  output  DATA_WIDTH  parallel output register
ser_clk  output  1  serial clock, idle 0
ser_data  output  1  serial data, idle 1
busy  output  1  shift engine active
irq  output  1  level interrupt, equal to done & irq_en

Behaviour:
- Reset is synchronous, active-high, and takes priority over all writes.
  - Reset values: out_port=RESET_VALUE; CTRL=0; state=IDLE; ser_clk=0; ser_data=1; busy=0; done=0; ovf=0; irq=0.
- Register map. Unused bits read 0; writes to unlisted addresses are ignored.
  - 0 DATA, R/W: out_port <= writedata[DATA_WIDTH-1:0]. Reads return out_port zero-extended.
  - 1 SET, W: out_port <= out_port | writedata[DATA_WIDTH-1:0]. Reads 0.
  - 2 CLEAR, W: out_port <= out_port & ~writedata[DATA_WIDTH-1:0]. Reads 0.
  - 3 CTRL, R/W: [DIV_WIDTH-1:0] div; [20:16] len_m1 (transfer length = len_m1+1, range 1..32 bits); [24] msb_first; [25] irq_en.
  - 4 SHIFT, W: load the shift word and start a transfer. Reads the last word written.
  - 5 STATUS, R/W1C: [0] busy (read-only); [1] done (W1C); [2] ovf (W1C).
- Parallel writes update out_port on the clock edge of the write, giving 1-cycle latency. The shift engine does not touch out_port.
- Shift FSM states: IDLE, LOW, HIGH.
  - IDLE, on a SHIFT write:
    - latch div, len_m1 and msb_first from CTRL;
    - load sreg from writedata and bitcnt from len_m1;
    - clear the phase counter and go to LOW.
  - First-bit timing: busy=1 and ser_data = first bit are valid the cycle after the write. The first bit is writedata[len_m1] if msb_first=1, otherwise writedata[0].
  - LOW: ser_clk=0. After div+1 cycles, go to HIGH.
  - HIGH: ser_clk=1. After div+1 cycles:
    - if bitcnt=0: go to IDLE, set done, busy=0, ser_data=1, ser_clk=0;
    - else: decrement bitcnt, shift to the next bit, update ser_data and go to LOW.
  - Data changes only on ser_clk falling edges, so it is stable across each rising edge.
  - Bit period is 2*(div+1) clk cycles. A transfer lasts (len_m1+1)*2*(div+1) cycles from the cycle after the write until busy falls.
- A SHIFT write while busy is ignored and sets ovf; the transfer in progress is unaffected.
- A CTRL write while busy takes effect at the next transfer only.
- If a done W1C coincides with transfer completion, the set wins and done stays 1. The same rule applies to ovf.
- irq is registered-equivalent combinational: done & irq_en. It stays high until done is cleared or irq_en is written 0.
- Reset during a transfer aborts it immediately. Next cycle: ser_clk=0, ser_data=1, busy=0, done=0, IDLE.
- div=0 is legal and gives a 2-cycle bit period.

Test Plan:
- DATA_WIDTH=8: write DATA=0xA5, then SET=0x0A, then CLEAR=0x81 -> out_port is 0xA5, then 0xAF, then 0x2E on successive cycles; reading addr 0 returns 0x0000002E.
- CTRL: div=1, len_m1=3, msb_first=1; SHIFT=0xB -> ser_data sequence is 1,0,1,1. Each bit is held 4 cycles, with ser_clk low 2 and high 2. busy is high for exactly 16 cycles. STATUS then reads 0x2.
- Same setup with msb_first=0 and SHIFT=0xB -> ser_data sequence is 1,1,0,1.
- irq_en=1: after a transfer completes, irq=1. Write STATUS=0x2 -> irq=0 next cycle. Repeat with the W1C issued on the completion cycle -> done stays 1.
- SHIFT write mid-transfer -> STATUS reads 0x5 (busy and ovf) and the original bit stream is unchanged. CTRL div=0, len_m1=31 -> transfer takes exactly 64 cycles.
- Assert reset for 1 cycle mid-transfer -> next cycle ser_clk=0, ser_data=1, busy=0, out_port=RESET_VALUE. A new SHIFT write then starts a transfer normally.
